trap_sequencer: RTL and testbench

Trap entry controller that drives the Trap Base Register's write port and sequences SPARC trap entry. Samples exception request lines, selects the highest-priority one, and loads its trap type into the TBR (`Trap_Type`, `TBR_tt_Ld`). It then issues the PSR and window update and the PC/nPC save strobes, and finally loads the PC with the vector `{TBA, tt, 4'b0000}` read back from the TBR. It sits in the control unit between the exception sources and the TBR/PSR/PC registers.

---
 rtl/trap_sequencer.sv | 145 ++++++++++++++
 tb/tb_trap_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap entry sequencer: picks the highest-priority exception, writes its tt into the TBR,
// strobes the PSR/window update and PC/nPC saves, then vectors the PC through {TBA, tt, 0}.
module trap_sequencer #(
  parameter int unsigned NWINDOWS = 32,
  parameter int unsigned CWP_W    = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [6:0]       Trap_Req,
  input  logic             ET,
  input  logic             S,
  input  logic [CWP_W-1:0] CWP,
  input  logic [24:0]      TBA,
  input  logic [2:0]       tt,
  output logic [6:0]       Trap_Type,
  output logic             TBR_tt_Ld,
  output logic             PSR_Trap_Ld,
  output logic             S_Saved,
  output logic [CWP_W-1:0] New_CWP,
  output logic             Save_PC_Ld,
  output logic             Save_nPC_Ld,
  output logic             PC_Vector_Ld,
  output logic [31:0]      Vector_Addr,
  output logic [6:0]       Trap_Ack,
  output logic             Trap_Active,
  output logic             Error_Mode
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SAVE    = 3'd2,
    VECTOR  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t     r_state;
  logic [2:0] r_p;
  logic [6:0] r_trap_type;
  logic       r_tt_ld;
  logic       r_psr_ld;
  logic       r_s_saved;
  logic       r_save_pc;
  logic       r_save_npc;
  logic       r_vec_ld;
  logic [6:0] r_ack;
  logic       r_active;
  logic       r_error;

  logic [2:0] w_p;
  logic       w_found;

  // Lowest set request bit wins.
  always_comb begin
    w_p     = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (Trap_Req[i] && !w_found) begin
        w_p     = 3'(i);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_trap_type <= '0;
      r_tt_ld     <= 1'b0;
      r_psr_ld    <= 1'b0;
      r_s_saved   <= 1'b0;
      r_save_pc   <= 1'b0;
      r_save_npc  <= 1'b0;
      r_vec_ld    <= 1'b0;
      r_ack       <= '0;
      r_active    <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // Strobes are single-cycle; each state re-raises only its own.
      r_trap_type <= '0;
      r_tt_ld     <= 1'b0;
      r_psr_ld    <= 1'b0;
      r_save_pc   <= 1'b0;
      r_save_npc  <= 1'b0;
      r_vec_ld    <= 1'b0;
      r_ack       <= '0;
      case (r_state)
        IDLE: begin
          if (|Trap_Req) begin
            r_active <= 1'b1;
            if (ET) begin
              r_p         <= w_p;
              r_s_saved   <= S;
              r_trap_type <= {4'b0000, w_p + 3'd1};
              r_tt_ld     <= 1'b1;
              r_state     <= CAPTURE;
            end else begin
              r_error <= 1'b1;
              r_state <= ERROR;
            end
          end
        end
        CAPTURE: begin
          r_psr_ld   <= 1'b1;
          r_save_pc  <= 1'b1;
          r_save_npc <= 1'b1;
          r_state    <= SAVE;
        end
        SAVE: begin
          r_vec_ld <= 1'b1;
          r_ack    <= 7'b0000001 << r_p;
          r_state  <= VECTOR;
        end
        VECTOR: begin
          r_active <= 1'b0;
          r_state  <= IDLE;
        end
        ERROR: begin
          r_error  <= 1'b1;
          r_active <= 1'b1;
        end
        default: begin
          r_active <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign Trap_Type    = r_trap_type;
  assign TBR_tt_Ld    = r_tt_ld;
  assign PSR_Trap_Ld  = r_psr_ld;
  assign S_Saved      = r_s_saved;
  assign Save_PC_Ld   = r_save_pc;
  assign Save_nPC_Ld  = r_save_npc;
  assign PC_Vector_Ld = r_vec_ld;
  assign Trap_Ack     = r_ack;
  assign Trap_Active  = r_active;
  assign Error_Mode   = r_error;

  assign New_CWP     = (CWP == '0) ? CWP_W'(NWINDOWS - 1) : CWP - CWP_W'(1);
  assign Vector_Addr = {TBA, tt, 4'b0000};

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a small falling-edge TBR tt model.
module tb_trap_sequencer;

  logic        Clock;
  logic        Reset;
  logic [6:0]  Trap_Req;
  logic        ET;
  logic        S;
  logic [4:0]  CWP;
  logic [24:0] TBA;
  logic [2:0]  tbr_tt;
  logic [6:0]  Trap_Type;
  logic        TBR_tt_Ld;
  logic        PSR_Trap_Ld;
  logic        S_Saved;
  logic [4:0]  New_CWP;
  logic        Save_PC_Ld;
  logic        Save_nPC_Ld;
  logic        PC_Vector_Ld;
  logic [31:0] Vector_Addr;
  logic [6:0]  Trap_Ack;
  logic        Trap_Active;
  logic        Error_Mode;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  trap_sequencer #(.NWINDOWS(32), .CWP_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .Trap_Req(Trap_Req), .ET(ET), .S(S), .CWP(CWP),
    .TBA(TBA), .tt(tbr_tt), .Trap_Type(Trap_Type), .TBR_tt_Ld(TBR_tt_Ld),
    .PSR_Trap_Ld(PSR_Trap_Ld), .S_Saved(S_Saved), .New_CWP(New_CWP),
    .Save_PC_Ld(Save_PC_Ld), .Save_nPC_Ld(Save_nPC_Ld), .PC_Vector_Ld(PC_Vector_Ld),
    .Vector_Addr(Vector_Addr), .Trap_Ack(Trap_Ack), .Trap_Active(Trap_Active),
    .Error_Mode(Error_Mode)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // TBR tt field writes on the falling edge inside CAPTURE.
  initial tbr_tt = '0;
  always @(negedge Clock) if (TBR_tt_Ld) tbr_tt <= Trap_Type[2:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " strobes"}, {27'd0, TBR_tt_Ld, PSR_Trap_Ld, Save_PC_Ld, Save_nPC_Ld,
             PC_Vector_Ld}, 32'd0);
    check_eq({tag, " Trap_Type"}, {25'd0, Trap_Type}, 32'd0);
    check_eq({tag, " Trap_Ack"}, {25'd0, Trap_Ack}, 32'd0);
    check_eq({tag, " Trap_Active"}, {31'd0, Trap_Active}, 32'd0);
    check_eq({tag, " Error_Mode"}, {31'd0, Error_Mode}, 32'd0);
    check_eq({tag, " S_Saved"}, {31'd0, S_Saved}, 32'd0);
  endtask

  // Called with the request already applied in IDLE; ends in the IDLE cycle after VECTOR.
  task automatic run_trap(input logic [2:0] ett, input logic [4:0] ecwp, input logic es,
                          input logic [6:0] raise);
    logic [6:0]  ack;
    logic [31:0] vaddr;
    ack   = 7'b0000001 << (ett - 3'd1);
    vaddr = {TBA, ett, 4'b0000};
    step();
    check_eq("cap Trap_Type", {25'd0, Trap_Type}, {29'd0, ett});
    check_eq("cap TBR_tt_Ld", {31'd0, TBR_tt_Ld}, 32'd1);
    check_eq("cap Trap_Active", {31'd0, Trap_Active}, 32'd1);
    check_eq("cap PSR_Trap_Ld", {31'd0, PSR_Trap_Ld}, 32'd0);
    step();
    check_eq("save PSR_Trap_Ld", {31'd0, PSR_Trap_Ld}, 32'd1);
    check_eq("save Save_PC_Ld", {31'd0, Save_PC_Ld}, 32'd1);
    check_eq("save Save_nPC_Ld", {31'd0, Save_nPC_Ld}, 32'd1);
    check_eq("save New_CWP", {27'd0, New_CWP}, {27'd0, ecwp});
    check_eq("save S_Saved", {31'd0, S_Saved}, {31'd0, es});
    check_eq("save TBR_tt_Ld", {31'd0, TBR_tt_Ld}, 32'd0);
    check_eq("save Trap_Type", {25'd0, Trap_Type}, 32'd0);
    Trap_Req = Trap_Req | raise;
    step();
    check_eq("vec PC_Vector_Ld", {31'd0, PC_Vector_Ld}, 32'd1);
    check_eq("vec Trap_Ack", {25'd0, Trap_Ack}, {25'd0, ack});
    check_eq("vec Vector_Addr", Vector_Addr, vaddr);
    check_eq("vec PSR_Trap_Ld", {31'd0, PSR_Trap_Ld}, 32'd0);
    Trap_Req = Trap_Req & ~ack;
    step();
    check_eq("idle Trap_Active", {31'd0, Trap_Active}, 32'd0);
    check_eq("idle PC_Vector_Ld", {31'd0, PC_Vector_Ld}, 32'd0);
    check_eq("idle Trap_Ack", {25'd0, Trap_Ack}, 32'd0);
    check_eq("idle TBR_tt_Ld", {31'd0, TBR_tt_Ld}, 32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    Trap_Req = '0;
    ET       = 1'b1;
    S        = 1'b1;
    CWP      = 5'd5;
    TBA      = 25'h0000003;
    #2 Reset = 1'b0;
    #5;
    check_all_zero("reset");
    step();
    check_all_zero("reset held");
    Reset = 1'b1;
    step();
    check_eq("post-reset idle", {31'd0, Trap_Active}, 32'd0);

    // Single trap, tt 3 -> vector 0x1B0.
    Trap_Req = 7'b0000100;
    run_trap(3'd3, 5'd4, 1'b1, 7'b0);
    check_eq("single addr const", Vector_Addr, 32'h000001B0);

    // Priority: three pending requests serviced lowest-bit first, 4 cycles apart.
    CWP      = 5'd9;
    Trap_Req = 7'b1010010;
    run_trap(3'd2, 5'd8, 1'b1, 7'b0);
    run_trap(3'd5, 5'd8, 1'b1, 7'b0);
    run_trap(3'd7, 5'd8, 1'b1, 7'b0);
    check_eq("prio drained", {25'd0, Trap_Req}, 32'd0);

    // CWP wrap with S=0.
    CWP      = 5'd0;
    S        = 1'b0;
    Trap_Req = 7'b0000001;
    run_trap(3'd1, 5'd31, 1'b0, 7'b0);

    // Request raised mid-trap is ignored until the next IDLE sample.
    CWP      = 5'd3;
    S        = 1'b1;
    Trap_Req = 7'b0001000;
    run_trap(3'd4, 5'd2, 1'b1, 7'b0000001);
    run_trap(3'd1, 5'd2, 1'b1, 7'b0);

    // Reset asserted in SAVE aborts the sequence asynchronously.
    Trap_Req = 7'b0000010;
    step();
    check_eq("abort cap", {31'd0, TBR_tt_Ld}, 32'd1);
    step();
    check_eq("abort save", {31'd0, PSR_Trap_Ld}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check_all_zero("async reset");
    Trap_Req = '0;
    step();
    check_eq("abort no vector", {31'd0, PC_Vector_Ld}, 32'd0);
    Reset = 1'b1;
    step();
    check_all_zero("abort idle");
    step();
    check_eq("abort still no vector", {31'd0, PC_Vector_Ld}, 32'd0);

    // ET=0 with a request enters sticky error mode.
    ET       = 1'b0;
    Trap_Req = 7'b0000001;
    step();
    check_eq("err Error_Mode", {31'd0, Error_Mode}, 32'd1);
    check_eq("err Trap_Active", {31'd0, Trap_Active}, 32'd1);
    check_eq("err TBR_tt_Ld", {31'd0, TBR_tt_Ld}, 32'd0);
    check_eq("err strobes", {27'd0, PSR_Trap_Ld, Save_PC_Ld, Save_nPC_Ld, PC_Vector_Ld,
             TBR_tt_Ld}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      Trap_Req = (i % 2 == 0) ? 7'b0000000 : 7'b0100100;
      ET       = (i >= 2);
      step();
      check_eq("err sticky", {31'd0, Error_Mode}, 32'd1);
      check_eq("err no tt load", {31'd0, TBR_tt_Ld}, 32'd0);
      check_eq("err no ack", {25'd0, Trap_Ack}, 32'd0);
    end
    Reset = 1'b0;
    #1;
    check_eq("err cleared", {31'd0, Error_Mode}, 32'd0);
    check_eq("err inactive", {31'd0, Trap_Active}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
